sgnmpy_accum: RTL

- Downstream consumer of the signed 32x32 multiplier product stream: accumulates a programmable number of signed products, rounds, shifts, saturates and emits one narrowed sum per block.
- i_aux from the multiplier is the product-valid tag.
- Shares the multiplier's i_clk and i_ce so the two stall together.
- Target: dot-product and FIR tap sums.

---
 rtl/sgnmpy_accum.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sgnmpy_accum.sv
// Block accumulator for signed multiplier products: sums i_len+1 products, rounds half-up,
// shifts right by SHIFT and saturates to NOUT bits; o_valid two i_ce edges after the last accept.
module sgnmpy_accum #(
  parameter int NP    = 64,
  parameter int LGN   = 4,
  parameter int NACC  = 68,
  parameter int SHIFT = 32,
  parameter int NOUT  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_ce,
  input  logic signed [NP-1:0]   i_p,
  input  logic                   i_aux,
  input  logic        [LGN-1:0]  i_len,
  output logic signed [NOUT-1:0] o_sum,
  output logic                   o_valid,
  output logic                   o_ovfl,
  output logic                   o_busy
);

  localparam int RW = NACC + 1;
  localparam logic        [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))
                                                      : {RW{1'b0}};
  localparam logic signed [RW-1:0] SMAX = {{(RW-NOUT+1){1'b0}}, {(NOUT-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-NOUT+1){1'b1}}, {(NOUT-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_q, state_d;
  logic signed [NACC-1:0] acc_q, acc_d;
  logic signed [NACC-1:0] fin_q, fin_d;
  logic                   fvld_q, fvld_d;
  logic        [LGN-1:0]  cnt_q, cnt_d;
  logic        [LGN-1:0]  len_q, len_d;
  logic signed [NOUT-1:0] sum_q, sum_d;
  logic                   ovfl_q, ovfl_d;
  logic                   vld_q;

  logic signed [NACC-1:0] p_ext;
  logic signed [RW-1:0]   rnd_r;
  logic signed [RW-1:0]   shf_s;

  assign p_ext = {{(NACC-NP){i_p[NP-1]}}, i_p};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fin_d   = fin_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fvld_d  = 1'b0;
    if (i_aux) begin
      case (state_q)
        IDLE: begin
          if (i_len == '0) begin
            fin_d  = p_ext;
            fvld_d = 1'b1;
          end else begin
            acc_d   = p_ext;
            len_d   = i_len;
            cnt_d   = LGN'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          // len_q was latched on the first product; i_len is ignored mid-block
          if (cnt_q == len_q) begin
            fin_d   = acc_q + p_ext;
            fvld_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q + p_ext;
            cnt_d = cnt_q + LGN'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Rounding add carries one extra bit so the largest accumulator cannot wrap.
  always_comb begin
    rnd_r = {fin_q[NACC-1], fin_q} + RND;
    shf_s = rnd_r >>> SHIFT;
    sum_d = shf_s[NOUT-1:0];
    ovfl_d = 1'b0;
    if (shf_s > SMAX) begin
      sum_d  = {1'b0, {(NOUT-1){1'b1}}};
      ovfl_d = 1'b1;
    end else if (shf_s < SMIN) begin
      sum_d  = {1'b1, {(NOUT-1){1'b0}}};
      ovfl_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fin_q   <= '0;
      fvld_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      ovfl_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else if (i_ce) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fin_q   <= fin_d;
      fvld_q  <= fvld_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      vld_q   <= fvld_q;
      if (fvld_q) begin
        sum_q  <= sum_d;
        ovfl_q <= ovfl_d;
      end
    end
  end

  assign o_sum   = sum_q;
  assign o_valid = vld_q;
  assign o_ovfl  = ovfl_q;
  assign o_busy  = (state_q == ACCUM);

endmodule
